// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: load data types, write-enable levels,
// the all-zero data word and FSM state codes.
package wb_stage_pkg;

  localparam logic [2:0] DT_BYTE  = 3'd0;
  localparam logic [2:0] DT_HALF  = 3'd1;
  localparam logic [2:0] DT_WORD  = 3'd2;
  localparam logic [2:0] DT_UBYTE = 3'd3;
  localparam logic [2:0] DT_UHALF = 3'd4;
  localparam logic [2:0] DT_DWORD = 3'd5;
  localparam logic [2:0] DT_UWORD = 3'd6;

  localparam logic W_ENABLE  = 1'b1;
  localparam logic W_DISABLE = 1'b0;

  localparam logic [63:0] DATA_ZERO = 64'd0;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

  // Access size in bytes; undefined codes report 1 so they never look misaligned.
  function automatic logic [3:0] dt_size(input logic [2:0] dt, input logic wide);
    logic [3:0] sz;
    case (dt)
      DT_BYTE, DT_UBYTE: sz = 4'd1;
      DT_HALF, DT_UHALF: sz = 4'd2;
      DT_WORD:           sz = 4'd4;
      DT_UWORD:          sz = wide ? 4'd4 : 4'd1;
      DT_DWORD:          sz = wide ? 4'd8 : 4'd1;
      default:           sz = 4'd1;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load lane select plus sign/zero extension for the writeback stage.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                    data_type,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
  input  logic [DATA_W-1:0]             rdata,
  output logic [DATA_W-1:0]             data
);

  logic [DATA_W-1:0] lane;

  // Shifting right brings the addressed byte to bit 0; bytes past the bus top become zero.
  assign lane = rdata >> {byte_off, 3'b000};

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    logic signed [7:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] zext32(input logic [31:0] v);
    return DATA_W'(v);
  endfunction

  always_comb begin
    data = DATA_ZERO[DATA_W-1:0];
    case (data_type)
      DT_BYTE:  data = sext8(lane[7:0]);
      DT_UBYTE: data = zext8(lane[7:0]);
      DT_HALF:  data = sext16(lane[15:0]);
      DT_UHALF: data = zext16(lane[15:0]);
      DT_WORD:  data = sext32(lane[31:0]);
      DT_UWORD: if (DATA_W == 64) data = zext32(lane[31:0]);
      DT_DWORD: if (DATA_W == 64) data = lane;
      default:  data = DATA_ZERO[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: ALU writes, load wait with timeout, single register-file port.
// Optional WB_MISALIGN_CHECK_EN adds misalign_o and rejects misaligned loads at accept.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          ex_w_reg_enable_i,
  input  logic                          mem_w_reg_enable_i,
  input  logic [REG_AW-1:0]             w_reg_addr_i,
  input  logic [DATA_W-1:0]             ex_w_reg_data_i,
  input  logic [2:0]                    data_type_i,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_off_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
`ifdef WB_MISALIGN_CHECK_EN
  output logic                          misalign_o,
`endif
  output logic [REG_AW-1:0]             w_reg_addr_o,
  output logic [DATA_W-1:0]             w_reg_data_o,
  output logic                          w_reg_enable_o,
  output logic                          load_busy_o,
  output logic                          load_err_o
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              load_take;
  logic              misaligned;
  logic [REG_AW-1:0] ld_addr_p0;
  logic [2:0]        ld_type_p0;
  logic [OFF_W-1:0]  ld_off_p0;
  logic [DATA_W-1:0] ld_data;

  // Reset gates the handshake so nothing is accepted while rst is high.
  assign in_ready_o  = (state == ST_IDLE) && !rst;
  assign load_busy_o = (state == ST_WAIT_LOAD) && !rst;
  assign accept      = in_valid_i && in_ready_o;
  assign load_take   = accept && !ex_w_reg_enable_i && mem_w_reg_enable_i && !misaligned;
  assign cnt_inc     = cnt + 1'b1;

`ifdef WB_MISALIGN_CHECK_EN
  logic [3:0] acc_size;
  assign acc_size   = dt_size(data_type_i, DATA_W == 64);
  assign misaligned = (4'(byte_off_i) & (acc_size - 4'd1)) != 4'd0;

  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= accept && !ex_w_reg_enable_i && mem_w_reg_enable_i && misaligned;
  end
`else
  assign misaligned = 1'b0;
`endif

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .data_type (ld_type_p0),
    .byte_off  (ld_off_p0),
    .rdata     (mem_rdata_i),
    .data      (ld_data)
  );

  // Stage p0: pending load descriptor, held for the whole wait
  always_ff @(posedge clk) begin
    if (load_take) begin
      ld_addr_p0 <= w_reg_addr_i;
      ld_type_p0 <= data_type_i;
      ld_off_p0  <= byte_off_i;
    end
  end

  // Stage p1: FSM, timeout counter and register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      w_reg_enable_o <= W_DISABLE;
      load_err_o     <= 1'b0;
      w_reg_addr_o   <= '0;
      w_reg_data_o   <= DATA_ZERO[DATA_W-1:0];
    end else begin
      w_reg_enable_o <= W_DISABLE;
      load_err_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && ex_w_reg_enable_i) begin
            w_reg_addr_o   <= w_reg_addr_i;
            w_reg_data_o   <= ex_w_reg_data_i;
            w_reg_enable_o <= (w_reg_addr_i != '0) ? W_ENABLE : W_DISABLE;
          end else if (load_take) begin
            cnt   <= '0;
            state <= ST_WAIT_LOAD;
          end
        end
        ST_WAIT_LOAD: begin
          // A response in the final counted cycle still wins over the timeout.
          if (mem_rvalid_i) begin
            w_reg_addr_o   <= ld_addr_p0;
            w_reg_data_o   <= ld_data;
            w_reg_enable_o <= (ld_addr_p0 != '0) ? W_ENABLE : W_DISABLE;
            state          <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            if (cnt_inc == TO_VAL) begin
              load_err_o <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (DATA_W=32, TIMEOUT=15).
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        ex_en;
  logic        mem_en;
  logic [4:0]  addr_in;
  logic [31:0] ex_data;
  logic [2:0]  dtype;
  logic [1:0]  boff;
  logic        rvalid;
  logic [31:0] rdata;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic        busy;
  logic        err;
`ifdef WB_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int passed;
  int total;

  wb_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(15)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .ex_w_reg_enable_i  (ex_en),
    .mem_w_reg_enable_i (mem_en),
    .w_reg_addr_i       (addr_in),
    .ex_w_reg_data_i    (ex_data),
    .data_type_i        (dtype),
    .byte_off_i         (boff),
    .mem_rvalid_i       (rvalid),
    .mem_rdata_i        (rdata),
`ifdef WB_MISALIGN_CHECK_EN
    .misalign_o         (misalign),
`endif
    .w_reg_addr_o       (w_addr),
    .w_reg_data_o       (w_data),
    .w_reg_enable_o     (w_en),
    .load_busy_o        (busy),
    .load_err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid = 0; ex_en = 0; mem_en = 0; addr_in = 0; ex_data = 0;
    dtype = 0; boff = 0; rvalid = 0; rdata = 0;
  endtask

  // Presents a load for one accept edge; returns in the first WAIT_LOAD cycle.
  task automatic issue_load(input logic [4:0] a, input logic [2:0] t, input logic [1:0] o);
    in_valid = 1; ex_en = 0; mem_en = 1; addr_in = a; dtype = t; boff = o;
    step;
    in_valid = 0; mem_en = 0;
  endtask

  // Raises rvalid in the n-th wait cycle; returns just after the sampling edge.
  task automatic respond(input int n, input logic [31:0] d);
    repeat (n - 1) step;
    rvalid = 1; rdata = d;
    step;
    rvalid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    step;
    step;
    total++; if (w_en !== 1'b0) $display("FAIL rst_en got %b want 0", w_en); else passed++;
    total++; if (w_data !== 32'h0) $display("FAIL rst_data got %h want 00000000", w_data); else passed++;
    total++; if (w_addr !== 5'h0) $display("FAIL rst_addr got %h want 00", w_addr); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    rst = 0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; ex_en = 1; addr_in = 5'(i + 1); ex_data = vals[i];
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); else passed++;
      step;
      total++; if (w_en !== 1'b1) $display("FAIL b2b_en%0d got %b want 1", i, w_en); else passed++;
      total++; if (w_addr !== 5'(i + 1)) $display("FAIL b2b_addr%0d got %0d want %0d", i, w_addr, i + 1); else passed++;
      total++; if (w_data !== vals[i]) $display("FAIL b2b_data%0d got %h want %h", i, w_data, vals[i]); else passed++;
    end
    in_valid = 0; ex_en = 0;
    step;
    total++; if (w_en !== 1'b0) $display("FAIL b2b_idle_en got %b want 0", w_en); else passed++;
  endtask

  task automatic test_byte_load;
    issue_load(5'd5, DT_BYTE, 2'd2);
    rdata = 32'h0080_0000;
    for (int k = 0; k < 4; k++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL byte_ready_w%0d got %b want 0", k, in_ready); else passed++;
      total++; if (w_en !== 1'b0) $display("FAIL byte_early_en%0d got %b want 0", k, w_en); else passed++;
      if (k == 3) rvalid = 1;
      step;
    end
    rvalid = 0;
    total++; if (w_en !== 1'b1) $display("FAIL byte_en got %b want 1", w_en); else passed++;
    total++; if (w_addr !== 5'd5) $display("FAIL byte_addr got %0d want 5", w_addr); else passed++;
    total++; if (w_data !== 32'hFFFF_FF80) $display("FAIL byte_data got %h want ffffff80", w_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL byte_ready_after got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_half_loads;
    issue_load(5'd8, DT_UHALF, 2'd2);
    respond(2, 32'hBEEF_0000);
    total++; if (w_en !== 1'b1) $display("FAIL uhalf_en got %b want 1", w_en); else passed++;
    total++; if (w_data !== 32'h0000_BEEF) $display("FAIL uhalf_data got %h want 0000beef", w_data); else passed++;
    issue_load(5'd9, DT_HALF, 2'd2);
    respond(2, 32'hBEEF_0000);
    total++; if (w_data !== 32'hFFFF_BEEF) $display("FAIL half_data got %h want ffffbeef", w_data); else passed++;
    total++; if (w_addr !== 5'd9) $display("FAIL half_addr got %0d want 9", w_addr); else passed++;
    issue_load(5'd10, DT_UBYTE, 2'd3);
    respond(2, 32'hA500_0000);
    total++; if (w_data !== 32'h0000_00A5) $display("FAIL ubyte_data got %h want 000000a5", w_data); else passed++;
    issue_load(5'd11, DT_WORD, 2'd0);
    respond(3, 32'h8765_4321);
    total++; if (w_data !== 32'h8765_4321) $display("FAIL word_data got %h want 87654321", w_data); else passed++;
    issue_load(5'd12, 3'd7, 2'd0);
    respond(2, 32'hFFFF_FFFF);
    total++; if (w_en !== 1'b1) $display("FAIL undef_en got %b want 1", w_en); else passed++;
    total++; if (w_data !== 32'h0) $display("FAIL undef_data got %h want 00000000", w_data); else passed++;
`ifndef WB_MISALIGN_CHECK_EN
    // Half at offset 3 runs past the bus top: the upper lane byte reads as zero.
    issue_load(5'd13, DT_HALF, 2'd3);
    respond(2, 32'h80FF_FFFF);
    total++; if (w_data !== 32'h0000_0080) $display("FAIL overrun_data got %h want 00000080", w_data); else passed++;
`endif
  endtask

  task automatic test_timeout;
    issue_load(5'd7, DT_WORD, 2'd0);
    for (int k = 0; k < 15; k++) begin
      total++; if (err !== 1'b0 || w_en !== 1'b0) $display("FAIL to_early_w%0d got err=%b en=%b want 0/0", k, err, w_en); else passed++;
      step;
    end
    total++; if (err !== 1'b1) $display("FAIL to_err got %b want 1", err); else passed++;
    total++; if (w_en !== 1'b0) $display("FAIL to_en got %b want 0", w_en); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL to_ready got %b want 1", in_ready); else passed++;
    rvalid = 1; rdata = 32'h1234_5678;
    step;
    rvalid = 0;
    total++; if (err !== 1'b0) $display("FAIL to_pulse got %b want 0", err); else passed++;
    total++; if (w_en !== 1'b0) $display("FAIL to_late_en got %b want 0", w_en); else passed++;
  endtask

  task automatic test_rvalid_last;
    issue_load(5'd9, DT_WORD, 2'd0);
    respond(15, 32'hCAFE_F00D);
    total++; if (w_en !== 1'b1) $display("FAIL last_en got %b want 1", w_en); else passed++;
    total++; if (err !== 1'b0) $display("FAIL last_err got %b want 0", err); else passed++;
    total++; if (w_data !== 32'hCAFE_F00D) $display("FAIL last_data got %h want cafef00d", w_data); else passed++;
    step;
    total++; if (err !== 1'b0) $display("FAIL last_err_after got %b want 0", err); else passed++;
  endtask

  task automatic test_priority;
    in_valid = 1; ex_en = 1; mem_en = 1; addr_in = 5'd4; ex_data = 32'h44; dtype = DT_BYTE;
    step;
    in_valid = 0; ex_en = 0; mem_en = 0;
    total++; if (w_en !== 1'b1) $display("FAIL prio_en got %b want 1", w_en); else passed++;
    total++; if (w_data !== 32'h44) $display("FAIL prio_data got %h want 00000044", w_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL prio_busy got %b want 0", busy); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL prio_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_reset_mid_load;
    ex_data = 32'h99;
    in_valid = 1; ex_en = 1; addr_in = 5'd3;
    step;
    in_valid = 0; ex_en = 0;
    issue_load(5'd6, DT_WORD, 2'd0);
    step;
    rst = 1;
    step;
    rst = 0;
    total++; if (w_en !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_strobes got en=%b err=%b want 0/0", w_en, err); else passed++;
    total++; if (w_data !== 32'h0 || w_addr !== 5'h0) $display("FAIL rstmid_regs got %h/%0d want 0/0", w_data, w_addr); else passed++;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", in_ready); else passed++;
    rvalid = 1; rdata = 32'h5555_AAAA;
    step;
    rvalid = 0;
    total++; if (w_en !== 1'b0) $display("FAIL rstmid_late_en got %b want 0", w_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_reg0;
    in_valid = 1; ex_en = 1; addr_in = 5'd0; ex_data = 32'h55;
    step;
    in_valid = 0; ex_en = 0;
    total++; if (w_en !== 1'b0) $display("FAIL reg0_en got %b want 0", w_en); else passed++;
    total++; if (w_data !== 32'h55) $display("FAIL reg0_data got %h want 00000055", w_data); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    rst = 1;
    test_reset();
    test_back_to_back();
    test_byte_load();
    test_half_loads();
    test_timeout();
    test_rvalid_last();
    test_priority();
    test_reset_mid_load();
    test_reg0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
